thumb_hw_aligner: RTL and testbench
===================================

// Module: thumb_hw_aligner
// PURPOSE
//   Instruction-fetch front end of arm_core. Takes the 16-bit halfword stream from
//   instruction memory and assembles it into whole Thumb/Thumb-2 instructions.
//   A small output FIFO buffers the instructions, and the pre-decode/IT stage pops them.
//   Output layout: a 16-bit instruction is packed as {hw,16'h0}; a 32-bit instruction as
//   {first_hw,second_hw}. This matches pre-decode, which detects IT via inst[31:24]==8'hBF.
// PARAMETERS
//   FIFO_DEPTH   2    output FIFO entries; integer >= 1
//   CNT_W        2    width of the occupancy counter; must hold the value FIFO_DEPTH
// PORTS
//   clk          in   1   core clock; all state updates on posedge
//   rst          in   1   reset, asynchronous, active-low (0 = reset)
//   hw_in        in   16  next halfword from instruction memory
//   hw_valid     in   1   hw_in is valid this cycle
//   hw_ready     out  1   aligner accepts hw_in this cycle
//   flush        in   1   discard held halfword and all buffered instructions (branch/exception)
//   inst_out     out  32  head-of-FIFO instruction
//   inst_is32    out  1   head instruction is 32-bit
//   inst_valid   out  1   FIFO non-empty
//   inst_ready   in   1   pre-decode consumes the head this cycle
//   half_pending out  1   first halfword of a 32-bit instruction is held
// BEHAVIOUR
//   Reset (rst==0, asynchronous):
//     - count=0, state=EMPTY, hold=16'h0, all FIFO entries and pointers = 0.
//     - Outputs: inst_valid=0, inst_out=0, inst_is32=0, half_pending=0, hw_ready=1.
//     - Reset takes effect immediately, without waiting for a clock edge.
//   Handshake:
//     - hw_ready = (count < FIFO_DEPTH) & ~flush. Registered state only; no combinational
//       path from inst_ready.
//     - Accept = hw_valid & hw_ready.
//     - Pop = inst_valid & inst_ready & ~flush.
//   Width detection, applied only in state EMPTY:
//     - hw_in[15:11] in {5'b11101, 5'b11110, 5'b11111} means 32-bit prefix; anything else
//       is a 16-bit instruction.
//   State machine (2 states, half_pending = (state==HELD)):
//     - EMPTY, accept, 16-bit: push {hw_in,16'h0} with is32=0; stay EMPTY.
//     - EMPTY, accept, 32-bit prefix: hold<=hw_in; go to HELD. Nothing is pushed.
//     - HELD, accept: push {hold,hw_in} with is32=1; go to EMPTY. The second halfword is
//       never checked for a prefix.
//     - No accept: state and hold are unchanged.
//   FIFO:
//     - First-word-fall-through. A push at edge N is visible on inst_out/inst_valid after
//       edge N, so latency is 1 cycle from accepting the final halfword.
//     - Push and pop in the same cycle: count unchanged, both pointers advance.
//     - Pointers wrap modulo FIFO_DEPTH. Order is strict FIFO.
//     - No push is possible when full (hw_ready=0). Pop when empty is ignored.
//   Flush (synchronous, dominates every other event in that cycle):
//     - On the next edge: count=0, pointers=0, state=EMPTY, hold=0.
//     - No accept and no pop occur in the flush cycle.
//     - A held first halfword is discarded, so the next accepted halfword is
//       width-detected afresh.
//   Reset asserted mid-instruction (state HELD): the held halfword is lost, same as flush.
//   inst_out is don't-care-free: it always shows the head entry, 0 after reset or flush.
// TESTING
//   1. rst=0 between edges with FIFO non-empty -> inst_valid=0, inst_out=0, half_pending=0
//      immediately, and hw_ready=1.
//   2. hw_in=16'hBF08, hw_valid=1 for 1 cycle, inst_ready=0 -> next cycle
//      inst_out=32'hBF08_0000, inst_is32=0, inst_valid=1.
//   3. hw_in=16'hF000 then 16'hB800 on consecutive cycles -> half_pending=1 after the
//      first; after the second, exactly one entry 32'hF000_B800 with inst_is32=1.
//   4. inst_ready=0, push 16'h2001, 16'h2102, 16'h2203 -> hw_ready=0 after 2 pushes and
//      16'h2203 is stalled. Then inst_ready=1 -> 2001_0000, 2102_0000, 2203_0000 in order.
//   5. HELD with 16'hE92D, flush=1 for 1 cycle, then hw_in=16'h4770 -> output
//      32'h4770_0000, inst_is32=0; E92D is never emitted.
//   6. FIFO holds 1 entry with simultaneous accept(16'h4608) and pop -> count stays 1 and
//      the new head is 32'h4608_0000.

Source files
------------

// File: rtl/thumb_hw_aligner.sv
// Thumb/Thumb-2 halfword aligner: joins the 16-bit fetch stream into whole instructions
// and buffers them in a small first-word-fall-through FIFO for pre-decode.
module thumb_hw_aligner #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] hw_in,
    input  logic        hw_valid,
    output logic        hw_ready,
    input  logic        flush,
    output logic [31:0] inst_out,
    output logic        inst_is32,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        half_pending
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_t;

    state_t             state_r;
    logic [15:0]        hold_r;
    logic [CNT_W-1:0]   count_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [31:0]        data_mem_r [FIFO_DEPTH];
    logic               is32_mem_r [FIFO_DEPTH];

    logic               accept_s;
    logic               pop_s;
    logic               push_s;
    logic [31:0]        push_data_s;
    logic               push_is32_s;

    // Prefixes 11101, 11110 and 11111 open a 32-bit Thumb-2 encoding.
    function automatic logic is_prefix(input logic [15:0] hw);
        return (hw[15:11] == 5'b11101) || (hw[15:11] == 5'b11110) || (hw[15:11] == 5'b11111);
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign hw_ready     = (count_r < CNT_W'(FIFO_DEPTH)) & ~flush;
    assign inst_valid   = (count_r != {CNT_W{1'b0}});
    assign half_pending = (state_r == HELD);
    assign inst_out     = data_mem_r[rd_ptr_r];
    assign inst_is32    = is32_mem_r[rd_ptr_r];
    assign accept_s     = hw_valid & hw_ready;
    assign pop_s        = inst_valid & inst_ready & ~flush;

    // Decide what, if anything, the accepted halfword pushes into the FIFO.
    always_comb begin
        push_s      = 1'b0;
        push_data_s = 32'h0;
        push_is32_s = 1'b0;
        if (accept_s) begin
            case (state_r)
                EMPTY: begin
                    if (!is_prefix(hw_in)) begin
                        push_s      = 1'b1;
                        push_data_s = {hw_in, 16'h0};
                        push_is32_s = 1'b0;
                    end else begin
                        push_s      = 1'b0;
                    end
                end
                HELD: begin
                    push_s      = 1'b1;
                    push_data_s = {hold_r, hw_in};
                    push_is32_s = 1'b1;
                end
                default: begin
                    push_s      = 1'b0;
                end
            endcase
        end else begin
            push_s = 1'b0;
        end
    end

    // Alignment state, held halfword, FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= EMPTY;
            hold_r   <= 16'h0;
            count_r  <= {CNT_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else if (flush) begin
            state_r  <= EMPTY;
            hold_r   <= 16'h0;
            count_r  <= {CNT_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (accept_s) begin
                case (state_r)
                    EMPTY: begin
                        if (is_prefix(hw_in)) begin
                            state_r <= HELD;
                            hold_r  <= hw_in;
                        end else begin
                            state_r <= EMPTY;
                        end
                    end
                    HELD:    state_r <= EMPTY;
                    default: state_r <= EMPTY;
                endcase
            end
            if (push_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; cleared on flush so an empty head always reads as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem_r[i] <= 32'h0;
                is32_mem_r[i] <= 1'b0;
            end
        end else if (flush) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem_r[i] <= 32'h0;
                is32_mem_r[i] <= 1'b0;
            end
        end else if (push_s) begin
            data_mem_r[wr_ptr_r] <= push_data_s;
            is32_mem_r[wr_ptr_r] <= push_is32_s;
        end
    end

endmodule

// File: tb/tb_thumb_hw_aligner.sv
// Directed bench for thumb_hw_aligner: a vector table for single-cycle behaviour
// plus hand sequences for FIFO back-pressure and asynchronous reset.
module tb_thumb_hw_aligner;

    logic        clk;
    logic        rst;
    logic [15:0] hw_in;
    logic        hw_valid;
    logic        hw_ready;
    logic        flush;
    logic [31:0] inst_out;
    logic        inst_is32;
    logic        inst_valid;
    logic        inst_ready;
    logic        half_pending;

    int checks;
    int errors;

    thumb_hw_aligner #(.FIFO_DEPTH(2), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .hw_in(hw_in), .hw_valid(hw_valid), .hw_ready(hw_ready),
        .flush(flush), .inst_out(inst_out), .inst_is32(inst_is32), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .half_pending(half_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] hw;
        logic        v;
        logic        rdy;
        logic        fl;
        logic        exp_hwr;
        logic        exp_val;
        logic        chk_out;
        logic [31:0] exp_out;
        logic        exp_is32;
        logic        exp_pend;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] h, input logic v, input logic r, input logic f);
        hw_in      = h;
        hw_valid   = v;
        inst_ready = r;
        flush      = f;
    endtask

    initial begin
        // hw, v, rdy, fl, exp_hwr, exp_val, chk_out, exp_out, exp_is32, exp_pend
        tbl[0]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
        tbl[1]  = '{16'hBF08, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hBF08_0000, 1'b0, 1'b0};
        tbl[2]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[3]  = '{16'hF000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
        tbl[4]  = '{16'hB800, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hF000_B800, 1'b1, 1'b0};
        tbl[5]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hF000_B800, 1'b1, 1'b0};
        tbl[6]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[7]  = '{16'hE92D, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
        tbl[8]  = '{16'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
        tbl[9]  = '{16'h4770, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4770_0000, 1'b0, 1'b0};
        tbl[10] = '{16'h4608, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4608_0000, 1'b0, 1'b0};
        tbl[11] = '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[12] = '{16'h2001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2001_0000, 1'b0, 1'b0};
        tbl[13] = '{16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
        tbl[14] = '{16'hE800, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
        tbl[15] = '{16'hF800, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hE800_F800, 1'b1, 1'b0};
        tbl[16] = '{16'hE7FF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hE7FF_0000, 1'b0, 1'b0};
        tbl[17] = '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[18] = '{16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
        tbl[19] = '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
        tbl[20] = '{16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_0001, 1'b1, 1'b0};
        tbl[21] = '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};

        checks = 0;
        errors = 0;
        rst = 1'b0;
        drive(16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("reset_valid", {31'h0, inst_valid}, 32'h0);
        chk("reset_out", inst_out, 32'h0);
        chk("reset_pending", {31'h0, half_pending}, 32'h0);
        chk("reset_hw_ready", {31'h0, hw_ready}, 32'h1);
        rst = 1'b1;
        step();

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].hw, tbl[i].v, tbl[i].rdy, tbl[i].fl);
            #1;
            chk($sformatf("v%0d_hw_ready", i), {31'h0, hw_ready}, {31'h0, tbl[i].exp_hwr});
            step();
            drive(16'h0000, 1'b0, 1'b0, 1'b0);
            chk($sformatf("v%0d_valid", i), {31'h0, inst_valid}, {31'h0, tbl[i].exp_val});
            chk($sformatf("v%0d_pending", i), {31'h0, half_pending}, {31'h0, tbl[i].exp_pend});
            if (tbl[i].exp_val || tbl[i].chk_out) begin
                chk($sformatf("v%0d_out", i), inst_out, tbl[i].exp_out);
                chk($sformatf("v%0d_is32", i), {31'h0, inst_is32}, {31'h0, tbl[i].exp_is32});
            end
        end

        // Back-pressure: two entries fill the FIFO and the third halfword stalls.
        drive(16'h2001, 1'b1, 1'b0, 1'b0);
        step();
        drive(16'h2102, 1'b1, 1'b0, 1'b0);
        step();
        drive(16'h2203, 1'b1, 1'b0, 1'b0);
        #1;
        chk("full_hw_ready", {31'h0, hw_ready}, 32'h0);
        step();
        chk("full_head", inst_out, 32'h2001_0000);
        chk("full_stall_ready", {31'h0, hw_ready}, 32'h0);
        inst_ready = 1'b1;
        step();
        chk("drain_1", inst_out, 32'h2102_0000);
        chk("drain_1_ready", {31'h0, hw_ready}, 32'h1);
        step();
        hw_valid = 1'b0;
        chk("drain_2", inst_out, 32'h2203_0000);
        chk("drain_2_valid", {31'h0, inst_valid}, 32'h1);
        step();
        chk("drain_empty", {31'h0, inst_valid}, 32'h0);
        drive(16'h0000, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while a 16-bit entry is buffered and a prefix is held.
        drive(16'h2001, 1'b1, 1'b0, 1'b0);
        step();
        drive(16'hF000, 1'b1, 1'b0, 1'b0);
        step();
        drive(16'h0000, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_valid", {31'h0, inst_valid}, 32'h1);
        chk("pre_rst_pending", {31'h0, half_pending}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("async_rst_out", inst_out, 32'h0);
        chk("async_rst_pending", {31'h0, half_pending}, 32'h0);
        chk("async_rst_hw_ready", {31'h0, hw_ready}, 32'h1);
        step();
        rst = 1'b1;
        drive(16'h4770, 1'b1, 1'b0, 1'b0);
        step();
        drive(16'h0000, 1'b0, 1'b0, 1'b0);
        chk("post_rst_out", inst_out, 32'h4770_0000);
        chk("post_rst_is32", {31'h0, inst_is32}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
